// File: rtl/axilite_master.sv
// AXI-Lite master: backend write/read request pulses are queued in an ordered
// command FIFO and issued one at a time as AXI-Lite transactions. Writes are
// posted (no B channel); a write completes once both AW and W are accepted.
module axilite_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         axi_aclk,
    input  logic                         axi_aresetn,
    input  logic                         req_wstart,
    input  logic [ADDR_WIDTH-1:0]        req_waddr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    input  logic [DATA_WIDTH/8-1:0]      req_wstrb,
    input  logic                         req_rstart,
    input  logic [ADDR_WIDTH-1:0]        req_raddr,
    output logic [DATA_WIDTH-1:0]        req_rdata,
    output logic                         req_rdone,
    output logic                         req_wdone,
    output logic                         req_full,
    output logic [$clog2(DEPTH+1)-1:0]   req_level,
    output logic                         req_drop,
    output logic                         axi_awvalid,
    output logic [ADDR_WIDTH-1:0]        axi_awaddr,
    input  logic                         axi_awready,
    output logic                         axi_wvalid,
    output logic [DATA_WIDTH-1:0]        axi_wdata,
    output logic [DATA_WIDTH/8-1:0]      axi_wstrb,
    input  logic                         axi_wready,
    output logic                         axi_arvalid,
    output logic [ADDR_WIDTH-1:0]        axi_araddr,
    input  logic                         axi_arready,
    input  logic                         axi_rvalid,
    input  logic [DATA_WIDTH-1:0]        axi_rdata,
    output logic                         axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int ENT_W  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;

    typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

    state_t                 state_q, state_d;
    logic [ENT_W-1:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, r_slot;
    logic [LVL_W-1:0]       level_q, level_d, free_slots, n_enq;
    logic                   full_q, drop_q, drop_d;
    logic                   w_enq, r_enq, pop;
    logic [ENT_W-1:0]       w_entry, r_entry, head_entry;
    logic                   head_is_read;
    logic [ADDR_WIDTH-1:0]  issue_addr_q;
    logic [DATA_WIDTH-1:0]  issue_data_q;
    logic [STRB_W-1:0]      issue_strb_q;
    logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                   aw_fin, w_fin;
    logic                   wdone_q, wdone_d, rdone_q, rdone_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    // Enqueue admission: the write takes the first free slot, the read the next one.
    always_comb begin
        free_slots = LVL_W'(DEPTH) - level_q;
        w_enq      = req_wstart && (free_slots != '0);
        r_enq      = req_rstart && (w_enq ? (free_slots >= LVL_W'(2)) : (free_slots != '0));
        drop_d     = (req_wstart && !w_enq) || (req_rstart && !r_enq);
        n_enq      = LVL_W'(w_enq) + LVL_W'(r_enq);
        r_slot     = w_enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        w_entry    = {1'b0, req_waddr, req_wdata, req_wstrb};
        r_entry    = {1'b1, req_raddr, {DATA_WIDTH{1'b0}}, {STRB_W{1'b0}}};
        head_entry = fifo_mem[rd_ptr_q];
        head_is_read = head_entry[ENT_W-1];
        pop        = (state_q == IDLE) && (level_q != '0);
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_enq);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + n_enq - LVL_W'(pop);
    end

    // FIFO storage; emptiness is tracked by pointers/level, so no reset needed here.
    always_ff @(posedge axi_aclk) begin
        if (w_enq) fifo_mem[wr_ptr_q] <= w_entry;
        if (r_enq) fifo_mem[r_slot]   <= r_entry;
    end

    // Next-state and AXI channel outputs; payloads are zero outside their state.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wdone_d     = 1'b0;
        rdone_d     = 1'b0;
        rdata_d     = rdata_q;
        aw_fin      = 1'b0;
        w_fin       = 1'b0;
        axi_awvalid = 1'b0;
        axi_awaddr  = '0;
        axi_wvalid  = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_arvalid = 1'b0;
        axi_araddr  = '0;
        axi_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) state_d = head_is_read ? RD_ADDR : WRITE;
            end
            WRITE: begin
                axi_awvalid = !aw_done_q;
                axi_wvalid  = !w_done_q;
                axi_awaddr  = issue_addr_q;
                axi_wdata   = issue_data_q;
                axi_wstrb   = issue_strb_q;
                // A channel is finished if it completed earlier or handshakes now.
                aw_fin = aw_done_q || axi_awready;
                w_fin  = w_done_q  || axi_wready;
                if (aw_fin && w_fin) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wdone_d   = 1'b1;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            RD_ADDR: begin
                axi_arvalid = 1'b1;
                axi_araddr  = issue_addr_q;
                if (axi_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    rdata_d = axi_rdata;
                    rdone_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, FIFO bookkeeping and issue registers; reset abandons any transaction.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            drop_q       <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            wdone_q      <= 1'b0;
            rdone_q      <= 1'b0;
            rdata_q      <= '0;
            issue_addr_q <= '0;
            issue_data_q <= '0;
            issue_strb_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            full_q    <= (level_d == LVL_W'(DEPTH));
            drop_q    <= drop_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wdone_q   <= wdone_d;
            rdone_q   <= rdone_d;
            rdata_q   <= rdata_d;
            if (pop) begin
                issue_addr_q <= head_entry[ENT_W-2 -: ADDR_WIDTH];
                issue_data_q <= head_entry[DATA_WIDTH+STRB_W-1 -: DATA_WIDTH];
                issue_strb_q <= head_entry[STRB_W-1:0];
            end
        end
    end

    assign req_rdata = rdata_q;
    assign req_rdone = rdone_q;
    assign req_wdone = wdone_q;
    assign req_full  = full_q;
    assign req_level = level_q;
    assign req_drop  = drop_q;

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: latency, channel stalls, ordering,
// FIFO overflow and asynchronous reset during a read.
`timescale 1ns/1ps
module tb_axilite_master;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        req_wstart, req_rstart;
    logic [14:0] req_waddr, req_raddr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] req_rdata;
    logic        req_rdone, req_wdone, req_full, req_drop;
    logic [2:0]  req_level;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [14:0] axi_awaddr, axi_araddr;
    logic [31:0] axi_wdata, axi_rdata;
    logic [3:0]  axi_wstrb;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    int n_vec = 0;
    int n_err = 0;

    axilite_master #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .req_wstart(req_wstart), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .req_rstart(req_rstart), .req_raddr(req_raddr),
        .req_rdata(req_rdata), .req_rdone(req_rdone), .req_wdone(req_wdone),
        .req_full(req_full), .req_level(req_level), .req_drop(req_drop),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wready(axi_wready), .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr),
        .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata),
        .axi_rready(axi_rready)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    logic [14:0] exp_addr [5];
    logic [31:0] exp_data [5];
    logic [14:0] got_addr [8];
    logic [31:0] got_data [8];
    logic [31:0] echo;
    int          nc;
    int          rdone_cnt;
    int          aw_cnt;

    initial begin
        axi_aresetn = 1'b0;
        req_wstart = 0; req_rstart = 0; req_waddr = 0; req_raddr = 0;
        req_wdata = 0; req_wstrb = 0;
        axi_awready = 1; axi_wready = 1; axi_arready = 1; axi_rvalid = 0; axi_rdata = 0;
        tick(); tick();
        // Reset state
        chk("rst_level", req_level, 0);
        chk("rst_full", req_full, 0);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_rready}, 0);
        chk("rst_pulses", {req_rdone, req_wdone, req_drop}, 0);
        chk("rst_rdata", req_rdata, 0);
        axi_aresetn = 1'b1;
        tick();

        // 1: single write, readies high
        req_wstart = 1; req_waddr = 15'h0010; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        tick(); req_wstart = 0;
        chk("w1_level_n1", req_level, 1);
        chk("w1_awvalid_n1", axi_awvalid, 0);
        tick();
        chk("w1_valids_n2", {axi_awvalid, axi_wvalid}, 2'b11);
        chk("w1_awaddr", axi_awaddr, 15'h0010);
        chk("w1_wdata", axi_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", axi_wstrb, 4'hF);
        chk("w1_level_n2", req_level, 0);
        tick();
        chk("w1_wdone_n3", req_wdone, 1);
        chk("w1_valids_n3", {axi_awvalid, axi_wvalid}, 0);
        tick();
        chk("w1_wdone_n4", req_wdone, 0);

        // 2: wready delayed 3 cycles
        axi_wready = 0;
        req_wstart = 1; req_waddr = 15'h0020; req_wdata = 32'h11223344; req_wstrb = 4'h3;
        tick(); req_wstart = 0;
        tick();
        chk("w2_valids_c0", {axi_awvalid, axi_wvalid}, 2'b11);
        tick();
        chk("w2_valids_c1", {axi_awvalid, axi_wvalid}, 2'b01);
        chk("w2_wdata_c1", axi_wdata, 32'h11223344);
        tick();
        chk("w2_wvalid_c2", axi_wvalid, 1);
        chk("w2_wdata_c2", axi_wdata, 32'h11223344);
        tick();
        chk("w2_wvalid_c3", {axi_awvalid, axi_wvalid}, 2'b01);
        chk("w2_wstrb_c3", axi_wstrb, 4'h3);
        chk("w2_wdone_c3", req_wdone, 0);
        axi_wready = 1;
        tick();
        chk("w2_wdone", req_wdone, 1);
        chk("w2_wvalid_done", axi_wvalid, 0);
        tick();

        // 3: read with 2 stalled data cycles
        req_rstart = 1; req_raddr = 15'h0004;
        tick(); req_rstart = 0;
        tick();
        chk("r3_arvalid", axi_arvalid, 1);
        chk("r3_araddr", axi_araddr, 15'h0004);
        chk("r3_rready_ar", axi_rready, 0);
        tick();
        chk("r3_arvalid_off", axi_arvalid, 0);
        chk("r3_rready", axi_rready, 1);
        tick();
        tick();
        chk("r3_rdone_stall", req_rdone, 0);
        axi_rvalid = 1; axi_rdata = 32'h12345678;
        tick();
        axi_rvalid = 0; axi_rdata = 0;
        chk("r3_rdone", req_rdone, 1);
        chk("r3_rdata", req_rdata, 32'h12345678);
        chk("r3_rready_off", axi_rready, 0);
        tick();
        chk("r3_rdone_off", req_rdone, 0);
        chk("r3_rdata_held", req_rdata, 32'h12345678);

        // 4: same-cycle write+read to one register, slave echoes write data
        req_wstart = 1; req_waddr = 15'h0008; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'hF;
        req_rstart = 1; req_raddr = 15'h0008;
        tick(); req_wstart = 0; req_rstart = 0;
        chk("wr4_level2", req_level, 2);
        tick();
        chk("wr4_aw_first", {axi_awvalid, axi_wvalid, axi_arvalid}, 3'b110);
        echo = axi_wdata;
        tick();
        chk("wr4_wdone", req_wdone, 1);
        tick();
        chk("wr4_arvalid", {axi_awvalid, axi_arvalid}, 2'b01);
        chk("wr4_araddr", axi_araddr, 15'h0008);
        tick();
        chk("wr4_rready", axi_rready, 1);
        axi_rvalid = 1; axi_rdata = echo;
        tick();
        axi_rvalid = 0; axi_rdata = 0;
        chk("wr4_rdone", req_rdone, 1);
        chk("wr4_rdata", req_rdata, 32'hA5A5A5A5);
        tick();

        // 5: overflow with all readies stalled; a blocker write occupies the FSM
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        req_wstart = 1; req_waddr = 15'h00FC; req_wdata = 32'h0000B10C; req_wstrb = 4'hF;
        tick(); req_wstart = 0;
        tick();
        chk("ov5_blocker", axi_awvalid, 1);
        for (int i = 0; i < 6; i++) begin
            req_wstart = 1; req_waddr = 15'(15'h100 + 4 * i); req_wdata = 32'(i + 1);
            tick();
            chk($sformatf("ov5_level_%0d", i), req_level, (i < 4) ? i + 1 : 4);
            chk($sformatf("ov5_full_%0d", i), req_full, (i >= 3) ? 1 : 0);
            chk($sformatf("ov5_drop_%0d", i), req_drop, (i >= 4) ? 1 : 0);
        end
        req_wstart = 0;
        tick();
        chk("ov5_drop_end", req_drop, 0);
        exp_addr[0] = 15'h00FC; exp_data[0] = 32'h0000B10C;
        for (int i = 1; i < 5; i++) begin
            exp_addr[i] = 15'(15'h100 + 4 * (i - 1));
            exp_data[i] = 32'(i);
        end
        axi_awready = 1; axi_wready = 1;
        nc = 0;
        for (int c = 0; c < 40; c++) begin
            if (axi_awvalid && axi_awready) begin
                if (nc < 8) begin
                    got_addr[nc] = axi_awaddr;
                    got_data[nc] = axi_wdata;
                end
                nc++;
            end
            tick();
        end
        chk("ov5_issued", nc, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < nc) begin
                chk($sformatf("ov5_addr_%0d", i), got_addr[i], exp_addr[i]);
                chk($sformatf("ov5_data_%0d", i), got_data[i], exp_data[i]);
            end
        end
        chk("ov5_level_end", req_level, 0);

        // 6: reset in RD_DATA with two writes queued
        axi_arready = 1; axi_awready = 0; axi_wready = 0; axi_rvalid = 0;
        req_rstart = 1; req_raddr = 15'h0040;
        tick(); req_rstart = 0;
        req_wstart = 1; req_waddr = 15'h0200; req_wdata = 32'h1;
        tick();
        req_waddr = 15'h0204; req_wdata = 32'h2;
        tick(); req_wstart = 0;
        chk("rs6_rready", axi_rready, 1);
        chk("rs6_level", req_level, 2);
        #2 axi_aresetn = 1'b0;
        #1;
        chk("rs6_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_rready}, 0);
        chk("rs6_level0", req_level, 0);
        chk("rs6_full0", req_full, 0);
        tick(); tick();
        axi_aresetn = 1'b1;
        axi_rvalid = 1; axi_rdata = 32'hCAFEF00D;
        rdone_cnt = 0; aw_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (req_rdone) rdone_cnt++;
            if (axi_awvalid || axi_arvalid) aw_cnt++;
        end
        axi_rvalid = 0;
        chk("rs6_no_rdone", rdone_cnt, 0);
        chk("rs6_no_issue", aw_cnt, 0);
        chk("rs6_level_after", req_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
